// File: rtl/elastic_context_sequencer.sv
// Elastic context sequencer: per-stage context pointers over a shared config memory,
// with stage-to-stage ordering and a bounded lead of stage 0 over the last stage.
module elastic_context_sequencer #(
  parameter int unsigned STAGE_NUM    = 4,
  parameter int unsigned CONTEXT_SIZE = 16,
  parameter int unsigned CONFIG_WIDTH = 64,
  parameter int unsigned ITER_W       = 16,
  parameter int unsigned SKEW_MAX     = 2 * CONTEXT_SIZE,
  localparam int unsigned CTX_W       = $clog2(CONTEXT_SIZE)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              write_config_data,
  input  logic [CTX_W-1:0]                  config_index,
  input  logic [CONFIG_WIDTH-1:0]           config_data,
  input  logic                              start_exec,
  input  logic [CTX_W-1:0]                  mapping_context_max_id,
  input  logic [ITER_W-1:0]                 iteration_num,
  input  logic [STAGE_NUM-1:0]              switch_context,
  output logic [STAGE_NUM*CTX_W-1:0]        stage_context_id,
  output logic [STAGE_NUM*CONFIG_WIDTH-1:0] stage_config_data,
  output logic [STAGE_NUM-1:0]              stage_enable,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned CNT_W = ITER_W + CTX_W + 1;
  localparam int unsigned DEPTH = 1 << CTX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q [STAGE_NUM];
  logic [CNT_W-1:0]        cnt_d [STAGE_NUM];
  logic [CTX_W-1:0]        ctx_q [STAGE_NUM];
  logic [CTX_W-1:0]        ctx_d [STAGE_NUM];
  logic [CTX_W-1:0]        max_id_q, max_id_d;
  logic [CNT_W-1:0]        total_q, total_d;
  logic                    busy_q, done_q;
  logic [CONFIG_WIDTH-1:0] mem_q [DEPTH];

  logic                    run_c;
  logic [CNT_W-1:0]        lead_c;
  logic [STAGE_NUM-1:0]    en_c;
  logic                    wr_en_c;

  // Stage enables from registered counts only
  always_comb begin
    run_c  = (state_q == S_RUN);
    lead_c = cnt_q[0] - cnt_q[STAGE_NUM-1];
    en_c   = '0;
    en_c[0] = run_c && (cnt_q[0] < total_q) && (lead_c < CNT_W'(SKEW_MAX));
    for (int k = 1; k < STAGE_NUM; k++) begin
      en_c[k] = run_c && (cnt_q[k] < cnt_q[k-1]);
    end
  end

  assign stage_enable = en_c;
  assign busy         = busy_q;
  assign done         = done_q;

  // Next state: start_exec overrides everything, then accepted switches in RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctx_d    = ctx_q;
    max_id_d = max_id_q;
    total_d  = total_q;
    if (start_exec) begin
      max_id_d = mapping_context_max_id;
      total_d  = CNT_W'(iteration_num) * (CNT_W'(mapping_context_max_id) + CNT_W'(1));
      for (int k = 0; k < STAGE_NUM; k++) begin
        cnt_d[k] = '0;
        ctx_d[k] = '0;
      end
      state_d = (iteration_num == '0) ? S_DONE : S_RUN;
    end else if (run_c) begin
      for (int k = 0; k < STAGE_NUM; k++) begin
        if (switch_context[k] && en_c[k]) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
          ctx_d[k] = (ctx_q[k] == max_id_q) ? '0 : ctx_q[k] + CTX_W'(1);
        end
      end
      if (cnt_d[STAGE_NUM-1] == total_q) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      max_id_q <= '0;
      total_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < STAGE_NUM; k++) begin
        cnt_q[k] <= '0;
        ctx_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      max_id_q <= max_id_d;
      total_q  <= total_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
      cnt_q    <= cnt_d;
      ctx_q    <= ctx_d;
    end
  end

  // Config memory: writable only outside RUN, cleared by reset
  assign wr_en_c = write_config_data && !run_c && (32'(config_index) < CONTEXT_SIZE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[config_index] <= config_data;
    end
  end

  for (genvar k = 0; k < STAGE_NUM; k++) begin : g_stage_out
    assign stage_context_id[k*CTX_W +: CTX_W]              = ctx_q[k];
    assign stage_config_data[k*CONFIG_WIDTH +: CONFIG_WIDTH] = mem_q[ctx_q[k]];
  end

endmodule

// File: tb/tb_elastic_context_sequencer.sv
// Randomized bench for elastic_context_sequencer against a count-based reference model.
module tb_elastic_context_sequencer;

  localparam int NS   = 4;
  localparam int CS   = 16;
  localparam int CW   = 64;
  localparam int IW   = 16;
  localparam int SKEW = 4;
  localparam int CTXW = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               write_config_data = 1'b0;
  logic [CTXW-1:0]    config_index = '0;
  logic [CW-1:0]      config_data = '0;
  logic               start_exec = 1'b0;
  logic [CTXW-1:0]    mapping_context_max_id = '0;
  logic [IW-1:0]      iteration_num = '0;
  logic [NS-1:0]      switch_context = '0;
  logic [NS*CTXW-1:0] stage_context_id;
  logic [NS*CW-1:0]   stage_config_data;
  logic [NS-1:0]      stage_enable;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_cnt [NS];
  int          m_ctx [NS];
  int          m_total, m_max, m_st;
  logic [63:0] m_mem [CS];

  elastic_context_sequencer #(
    .STAGE_NUM(NS), .CONTEXT_SIZE(CS), .CONFIG_WIDTH(CW), .ITER_W(IW), .SKEW_MAX(SKEW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .write_config_data(write_config_data), .config_index(config_index), .config_data(config_data),
    .start_exec(start_exec), .mapping_context_max_id(mapping_context_max_id),
    .iteration_num(iteration_num), .switch_context(switch_context),
    .stage_context_id(stage_context_id), .stage_config_data(stage_config_data),
    .stage_enable(stage_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_cnt[k] = 0;
      m_ctx[k] = 0;
    end
    m_total = 0;
    m_max   = 0;
    m_st    = M_IDLE;
    for (int i = 0; i < CS; i++) m_mem[i] = '0;
  endtask

  // A stage may fire if it is behind its predecessor; stage 0 is bounded by total and skew
  function automatic bit m_en(int k);
    if (m_st != M_RUN) return 1'b0;
    if (k == 0) return (m_cnt[0] < m_total) && ((m_cnt[0] - m_cnt[NS-1]) < SKEW);
    return m_cnt[k] < m_cnt[k-1];
  endfunction

  task automatic check_outputs();
    check("busy", 64'(busy), 64'(m_st == M_RUN));
    check("done", 64'(done), 64'(m_st == M_DONE));
    for (int k = 0; k < NS; k++) begin
      check($sformatf("ctx%0d", k), 64'(stage_context_id[k*CTXW +: CTXW]), 64'(m_ctx[k]));
      check($sformatf("en%0d", k), 64'(stage_enable[k]), 64'(m_en(k)));
      check($sformatf("cfg%0d", k), stage_config_data[k*CW +: CW], m_mem[m_ctx[k]]);
    end
  endtask

  task automatic model_update(input bit s, input int mid, input int it, input logic [NS-1:0] sw,
                              input bit wr, input int idx, input logic [63:0] d);
    bit en [NS];
    for (int k = 0; k < NS; k++) en[k] = m_en(k);
    if (wr && m_st != M_RUN) m_mem[idx] = d;
    if (s) begin
      m_max   = mid;
      m_total = it * (mid + 1);
      for (int k = 0; k < NS; k++) begin
        m_cnt[k] = 0;
        m_ctx[k] = 0;
      end
      m_st = (it == 0) ? M_DONE : M_RUN;
    end else if (m_st == M_RUN) begin
      for (int k = 0; k < NS; k++) begin
        if (sw[k] && en[k]) begin
          m_cnt[k]++;
          m_ctx[k] = m_cnt[k] % (m_max + 1);
        end
      end
      if (m_cnt[NS-1] == m_total) m_st = M_DONE;
    end
  endtask

  // Called just after a falling edge: check, drive, advance one clock
  task automatic step(input bit s, input int mid, input int it, input logic [NS-1:0] sw,
                      input bit wr, input int idx, input logic [63:0] d);
    check_outputs();
    start_exec             = s;
    mapping_context_max_id = CTXW'(mid);
    iteration_num          = IW'(it);
    switch_context         = sw;
    write_config_data      = wr;
    config_index           = CTXW'(idx);
    config_data            = d;
    model_update(s, mid, it, sw, wr, idx, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // Program contexts 0..3, two passes, all stages switching every cycle
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, i, 64'h10 + 64'(i));
    step(1, 3, 2, '0, 0, 0, '0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 4'hF, 0, 0, '0);
    check("req34_done", 64'(done), 64'd1);
    check("req34_busy", 64'(busy), 64'd0);
    check("req34_ctx3", 64'(stage_context_id[3*CTXW +: CTXW]), 64'd0);
    idle(2);

    // Only stage 0 switching: skew bound stops it at four
    step(1, 3, 4, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 4'b0001, 0, 0, '0);
    check("skew_en", 64'(stage_enable), 64'h2);

    // Zero iterations goes straight to DONE
    step(1, 3, 0, '0, 0, 0, '0);
    check("zero_iter_done", 64'(done), 64'd1);
    check("zero_iter_en", 64'(stage_enable), 64'd0);
    idle(2);

    // Write ignored in RUN, accepted in DONE
    step(1, 3, 1, '0, 0, 0, '0);
    step(0, 0, 0, 4'b0001, 0, 0, '0);
    step(0, 0, 0, 4'b0001, 0, 0, '0);
    step(0, 0, 0, '0, 1, 2, 64'hDEAD_BEEF);
    check("cfg_run_ignored", stage_config_data[0 +: CW], 64'h12);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 4'hF, 0, 0, '0);
    check("cfg_done_state", 64'(done), 64'd1);
    step(0, 0, 0, '0, 1, 2, 64'hCAFE_F00D);
    step(1, 3, 1, '0, 0, 0, '0);
    step(0, 0, 0, 4'b0001, 0, 0, '0);
    step(0, 0, 0, 4'b0001, 0, 0, '0);
    check("cfg_done_written", stage_config_data[0 +: CW], 64'hCAFE_F00D);

    // Restart mid-run at cnt[0]=5
    step(1, 3, 4, '0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'hF, 0, 0, '0);
    step(1, 1, 3, 4'hF, 0, 0, '0);
    check("restart_ctx", 64'(stage_context_id), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 4'hF, 0, 0, '0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          s;
      bit          wr;
      logic [63:0] d;
      s  = ($urandom_range(0, 39) == 0);
      wr = ($urandom_range(0, 3) == 0);
      d  = {$urandom, $urandom};
      step(s, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), NS'($urandom),
           wr, int'($urandom_range(0, CS - 1)), d);
    end

    // Asynchronous reset in the middle of a run
    step(1, 3, 4, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 4'hF, 0, 0, '0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_rst_ctx", 64'(stage_context_id), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
